// File: rtl/pipe_pkg.sv
// Shared definitions for the front-end pipeline stall/flush controller:
// the status-state encoding and the constants loaded on reset and flush.
package pipe_pkg;

  // Last action taken by the controller, visible on the state output.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } pipe_state_t;

  // addi x0, x0, 0 -- the canonical RISC-V NOP parked in a squashed ID slot.
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Every bit of a squashed ID/EX control bundle takes this value.
  localparam logic CTRL_RST_BIT = 1'b0;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async reset value, synchronous clear
// (wins over load) and load enable. Holds when neither clear nor load.
module pipe_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear has priority so a squash cannot be undone by a concurrent load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= RST_VAL;
    else if (clr) q <= CLR_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Front-end pipeline state owner for the 5-stage core: PC, IF/ID and the
// ID/EX control register. Applies hold, bubble and flush actions from the
// hazard unit and the EX-stage branch redirect, and reports the last action.
// Optional feature macro: STALL_CNT_EN adds a saturating bubble counter.
//
// Valid semantics: valid_id/valid_ex qualify the contents of their slot
// (1 = real instruction). There is no ready/backpressure; holding is driven
// entirely by pc_write/if_id_write, and squashing by bubble/branch_taken.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
  parameter int               CTRL_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              bubble,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [31:0]       instr_if,
  input  logic [CTRL_W-1:0] ctrl_id,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_id,
  output logic [31:0]       instr_id,
  output logic              valid_id,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              valid_ex,
  output logic [1:0]        state,
  output logic [31:0]       stall_cnt
);

  localparam logic [CTRL_W:0] ID_EX_ZERO = {{CTRL_W{CTRL_RST_BIT}}, 1'b0};
  localparam logic [32:0]     IF_ID_SQ   = {NOP, 1'b0};

  logic [32:0]     if_id_q;
  logic [CTRL_W:0] id_ex_q;
  pipe_state_t     state_q;
  pipe_state_t     state_next;

  // PC: redirect on flush, otherwise advance by 4 (wrapping) when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             pc <= RESET_PC;
    else if (branch_taken) pc <= branch_target;
    else if (pc_write)     pc <= pc + XLEN'(4);
  end

  // IF/ID instruction + valid: squashed to NOP/invalid on flush.
  pipe_reg #(
    .W       (33),
    .RST_VAL (IF_ID_SQ),
    .CLR_VAL (IF_ID_SQ)
  ) u_if_id (
    .clk (clk),
    .rst (reset),
    .en  (if_id_write),
    .clr (branch_taken),
    .d   ({instr_if, 1'b1}),
    .q   (if_id_q)
  );

  // IF/ID PC: holds across a flush, loads only on a normal enabled cycle.
  pipe_reg #(
    .W       (XLEN),
    .RST_VAL ('0),
    .CLR_VAL ('0)
  ) u_pc_id (
    .clk (clk),
    .rst (reset),
    .en  (if_id_write & ~branch_taken),
    .clr (1'b0),
    .d   (pc),
    .q   (pc_id)
  );

  // ID/EX control + valid: zeroed on flush or bubble, else follows ID.
  pipe_reg #(
    .W       (CTRL_W + 1),
    .RST_VAL (ID_EX_ZERO),
    .CLR_VAL (ID_EX_ZERO)
  ) u_id_ex (
    .clk (clk),
    .rst (reset),
    .en  (1'b1),
    .clr (branch_taken | bubble),
    .d   ({ctrl_id, valid_id}),
    .q   (id_ex_q)
  );

  assign instr_id = if_id_q[32:1];
  assign valid_id = if_id_q[0];
  assign ctrl_ex  = id_ex_q[CTRL_W:1];
  assign valid_ex = id_ex_q[0];

  // Classify this cycle's action; flush outranks any stall request.
  always_comb begin
    state_next = RUN;
    if (branch_taken)
      state_next = FLUSH;
    else if (bubble || !pc_write || !if_id_write)
      state_next = STALL;
  end

  // Status register recording the action applied on the last edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_next;
  end

  assign state = state_q;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count bubbles that actually land (a flush in the same cycle does not).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (bubble && !branch_taken && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: reset, load-use stall, branch flush,
// flush-vs-bubble priority, PC wrap, mixed enables and the bubble counter.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        if_id_write;
  logic        bubble;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_if;
  logic [7:0]  ctrl_id;
  logic [31:0] pc;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic [7:0]  ctrl_ex;
  logic        valid_ex;
  logic [1:0]  state;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  localparam logic [31:0] NOP_V  = 32'h0000_0013;
  localparam logic [7:0]  CTRL_V = 8'hA5;

  pipe_stall_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .bubble        (bubble),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_if      (instr_if),
    .ctrl_id       (ctrl_id),
    .pc            (pc),
    .pc_id         (pc_id),
    .instr_id      (instr_id),
    .valid_id      (valid_id),
    .ctrl_ex       (ctrl_ex),
    .valid_ex      (valid_ex),
    .state         (state),
    .stall_cnt     (stall_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Set control inputs for the next edge.
  task automatic drive(input logic pw, input logic iw, input logic bb,
                       input logic br, input logic [31:0] tgt);
    pc_write      = pw;
    if_id_write   = iw;
    bubble        = bb;
    branch_taken  = br;
    branch_target = tgt;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    instr_if = 32'h1111_1111;
    ctrl_id  = CTRL_V;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
    tick();
    tick();

    // Asynchronous reset mid-run, away from an edge
    #2 reset = 1'b1;
    #1;
    check("rst_pc",       pc,                 32'h0);
    check("rst_valid_id", {31'd0, valid_id},  32'd0);
    check("rst_valid_ex", {31'd0, valid_ex},  32'd0);
    check("rst_state",    {30'd0, state},     32'd0);
    check("rst_instr_id", instr_id,           NOP_V);
    check("rst_pc_id",    pc_id,              32'h0);
    check("rst_ctrl_ex",  {24'd0, ctrl_ex},   32'd0);
    check("rst_cnt",      stall_cnt,          32'd0);
    tick();
    #2 reset = 1'b0;

    // Release: pc 4, 8, 12 on successive edges
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd12);
    instr_if = 32'h2222_2222;
    tick();
    check("rel_pc1",      pc,                exp_q.pop_front());
    check("rel_valid_id", {31'd0, valid_id}, 32'd1);
    check("rel_valid_ex", {31'd0, valid_ex}, 32'd0);
    check("rel_instr_id", instr_id,          32'h2222_2222);
    tick();
    check("rel_pc2",      pc,                exp_q.pop_front());
    check("rel_valid_ex2",{31'd0, valid_ex}, 32'd1);
    check("rel_ctrl_ex",  {24'd0, ctrl_ex},  {24'd0, CTRL_V});
    tick();
    check("rel_pc3",      pc,                exp_q.pop_front());
    instr_if = 32'h00C0_0093;
    tick();
    check("pre_pc",       pc,                32'h10);
    check("pre_instr_id", instr_id,          32'h00C0_0093);

    // Load-use stall
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    instr_if = 32'hDEAD_BEEF;
    tick();
    check("stl_pc",       pc,                32'h10);
    check("stl_instr_id", instr_id,          32'h00C0_0093);
    check("stl_pc_id",    pc_id,             32'hC);
    check("stl_ctrl_ex",  {24'd0, ctrl_ex},  32'd0);
    check("stl_valid_ex", {31'd0, valid_ex}, 32'd0);
    check("stl_state",    {30'd0, state},    32'd1);
`ifdef STALL_CNT_EN
    check("stl_cnt",      stall_cnt,         32'd1);
`else
    check("stl_cnt",      stall_cnt,         32'd0);
`endif
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    instr_if = 32'h0010_0113;
    tick();
    check("res_pc",       pc,                32'h14);
    check("res_instr_id", instr_id,          32'h0010_0113);
    check("res_pc_id",    pc_id,             32'h10);
    check("res_state",    {30'd0, state},    32'd0);
    check("res_valid_ex", {31'd0, valid_ex}, 32'd1);

    // Branch flush
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    tick();
    check("fl_pc",        pc,                32'h200);
    check("fl_instr_id",  instr_id,          NOP_V);
    check("fl_valid_id",  {31'd0, valid_id}, 32'd0);
    check("fl_pc_id",     pc_id,             32'h10);
    check("fl_valid_ex",  {31'd0, valid_ex}, 32'd0);
    check("fl_ctrl_ex",   {24'd0, ctrl_ex},  32'd0);
    check("fl_state",     {30'd0, state},    32'd2);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check("fl2_pc",       pc,                32'h204);
    check("fl2_pc_id",    pc_id,             32'h200);
    check("fl2_valid_id", {31'd0, valid_id}, 32'd1);
    check("fl2_valid_ex", {31'd0, valid_ex}, 32'd0);

    // Flush together with bubble and pc_write=0: flush wins
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h340);
    tick();
    check("sim_pc",       pc,                32'h340);
    check("sim_state",    {30'd0, state},    32'd2);
    check("sim_valid_id", {31'd0, valid_id}, 32'd0);
`ifdef STALL_CNT_EN
    check("sim_cnt",      stall_cnt,         32'd1);
`else
    check("sim_cnt",      stall_cnt,         32'd0);
`endif
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check("sim2_pc",      pc,                32'h344);

    // PC wrap-around
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    check("wr_pc0",       pc,                32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check("wr_pc1",       pc,                32'h0);
    check("wr_pc_id",     pc_id,             32'hFFFF_FFFC);

    // Mixed enables: PC advances, IF/ID holds
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("mx_pc",        pc,                32'h4);
    check("mx_pc_id",     pc_id,             32'hFFFF_FFFC);
    check("mx_state",     {30'd0, state},    32'd1);

    // Counter saturation
`ifdef STALL_CNT_EN
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
`endif
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_state",  {30'd0, state},    32'd1);
`ifdef STALL_CNT_EN
      check("sat_cnt",    stall_cnt,         32'hFFFF_FFFF);
`else
      check("sat_cnt",    stall_cnt,         32'd0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

- Owns the front-end pipeline state registers of the 5-stage RISC-V core: the PC, the IF/ID register and the ID/EX control register.
- Consumes the hazard unit's stall requests (pc_write, if_id_write, bubble) and the EX-stage branch redirect.
- Applies hold, bubble and flush actions cycle by cycle.
- Reports its last action as a status state.
- Optionally counts injected bubbles for performance analysis.

## Interface

Parameters:
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h0000_0000, PC value after reset
- CTRL_W, 8, width of the ID/EX control bundle

Ports:
- clk  in  1  core clock, all registers on rising edge
- reset  in  1  asynchronous, active-high reset
- pc_write  in  1  1 = PC may advance; 0 = hold PC
- if_id_write  in  1  1 = IF/ID may load; 0 = hold IF/ID
- bubble  in  1  1 = load zero control into ID/EX
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- branch_target  in  XLEN  redirect address, valid with branch_taken
- instr_if  in  32  instruction fetched at pc
- ctrl_id  in  CTRL_W  decoded control of the instruction in ID
- pc  out  XLEN  fetch address
- pc_id  out  XLEN  PC of the instruction in ID
- instr_id  out  32  instruction in ID
- valid_id  out  1  ID slot holds a real instruction
- ctrl_ex  out  CTRL_W  control bundle in EX
- valid_ex  out  1  EX slot holds a real instruction
- state  out  2  last action: RUN=0, STALL=1, FLUSH=2
- stall_cnt  out  32  bubbles injected (only with STALL_CNT_EN)

## Operation

Actions are evaluated every cycle in priority order: reset, then flush, then stall/normal.

**Flush (branch_taken=1)** overrides all stall inputs:
- pc <= branch_target
- instr_id <= NOP 32'h0000_0013, valid_id <= 0, pc_id holds
- ctrl_ex <= 0, valid_ex <= 0
- state <= FLUSH

**Otherwise**, each register group follows its own enable independently:
- PC: pc_write=1 loads pc+4, modulo 2^XLEN (wraps silently); pc_write=0 holds.
- IF/ID: if_id_write=1 loads {pc, instr_if, 1}; if_id_write=0 holds all three fields.
- ID/EX: bubble=1 loads ctrl_ex <= 0, valid_ex <= 0; otherwise ctrl_ex <= ctrl_id, valid_ex <= valid_id.
- state <= STALL if bubble=1 or pc_write=0 or if_id_write=0; else RUN.

Mixed enables, e.g. pc_write=1 with if_id_write=0, are legal and applied as given. The block makes no consistency check.

**Reset values:**
- pc=RESET_PC, pc_id=0, instr_id=NOP, valid_id=0
- ctrl_ex=0, valid_ex=0, state=RUN, stall_cnt=0

## Timing

- All outputs are registered and take effect on the edge following the input cycle. There is no combinational input-to-output path.
- Stall latency: asserting bubble in cycle N makes ctrl_ex=0 and valid_ex=0 visible in cycle N+1. pc and IF/ID are unchanged in N+1 when their enables were 0 in N.
- Flush latency: branch_taken in cycle N makes pc=branch_target in N+1, with both younger slots invalid. Fetch resumes at branch_target+4 in N+2.
- branch_taken and bubble asserted in the same cycle: the flush wins. The cycle counts as FLUSH, not STALL.
- Reset asserted mid-stall or mid-flush forces all reset values immediately, asynchronously.
- On reset release, the first rising edge performs a normal action.

## Configuration

STALL_CNT_EN
- **Defined:**
  - stall_cnt increments by 1 on every edge where bubble=1 and branch_taken=0.
  - It saturates at 32'hFFFF_FFFF.
  - Reset clears it to 0.
- **Undefined:**
  - stall_cnt is driven constant 0.
  - No counter flops are synthesized.

## Structure

- The shared package pipe_pkg holds:
  - the state enum (RUN, STALL, FLUSH)
  - the NOP constant 32'h0000_0013
  - the ctrl_ex reset constant, all zeros
- One sub-module is natural: pipe_reg. It is a parameterized-width register with async reset value, load enable and synchronous clear.
  - It is instantiated for the IF/ID fields and for the ID/EX control.
- The PC register, state register and counter live in the top.

## Test plan

1. **Reset.** Assert reset mid-run, then release; hold pc_write=if_id_write=1, bubble=0.
   - During reset: pc=0, valid_id=0, valid_ex=0, state=RUN.
   - After release: pc=4, 8, 12 on successive edges, and valid_id=1 after the first edge.
2. **Load-use stall.** One cycle of pc_write=0, if_id_write=0, bubble=1 with pc=0x10.
   - Next cycle: pc=0x10, instr_id unchanged, ctrl_ex=0, valid_ex=0, state=STALL.
   - The cycle after: pc=0x14.
3. **Branch flush.** branch_taken=1, branch_target=0x200.
   - Next cycle: pc=0x200, instr_id=0x00000013, valid_id=0, valid_ex=0, state=FLUSH.
4. **Simultaneous events.** branch_taken=1 together with bubble=1 and pc_write=0.
   - Required: pc=branch_target, state=FLUSH.
   - With STALL_CNT_EN, stall_cnt does not increment.
5. **Wrap-around.** pc=0xFFFF_FFFC with pc_write=1 -> pc=0x0000_0000 next cycle.
6. **Counter saturation (STALL_CNT_EN).** Preload via force to 0xFFFF_FFFE, then apply three bubble cycles.
   - Required: stall_cnt reads 0xFFFF_FFFF and stays there.
   - Rebuilt without the macro, stall_cnt remains 0 throughout.
